writeback_unit: RTL and testbench
=================================

# writeback_unit

Writeback stage that directly feeds the register file write port: selects the value to retire into rd and sequences loads through a valid/ready data-memory read interface. While a load is outstanding it stalls the core. It also sign- or zero-extends the returned byte, halfword or word and flags misaligned loads. It sits between the execute/decode datapath and `regfile` (`w_en`, `rd_id_i`, `rd_write_data_i`).

## Interface
- `LOAD_SEL`, default 2'b01: `ex_wb_sel_i` encoding for a load.
- `PC4_SEL`, default 2'b10: `ex_wb_sel_i` encoding for PC+4 (JAL/JALR); every other encoding selects the ALU result.
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ex_valid_i`  in  1  instruction present this cycle.
- `ex_reg_wen_i`  in  1  instruction writes rd.
- `ex_rd_id_i`  in  5  destination register.
- `ex_wb_sel_i`  in  2  writeback source select.
- `ex_alu_result_i`  in  32  ALU result; also the load address.
- `ex_pc_plus4_i`  in  32  PC+4.
- `ex_load_funct3_i`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other value is treated as LW.
- `mem_req_o`  out  1  read request valid.
- `mem_addr_o`  out  32  word-aligned address `{addr[31:2],2'b00}`.
- `mem_ready_i`  in  1  request accepted this cycle.
- `mem_rvalid_i`  in  1  read data valid.
- `mem_rdata_i`  in  32  read data word.
- `stall_o`  out  1  hold PC and the execute inputs.
- `w_en_o`, `rd_id_o` (5), `rd_write_data_o` (32)  out  drive the `regfile` write port.
- `load_misaligned_o`  out  1  one-cycle misaligned-load flag.

## Operation
- FSM states: IDLE, REQ, WAIT, WB.
- **IDLE, non-load** (`ex_valid_i` set, `ex_wb_sel_i != LOAD_SEL`):
  - Combinational writeback: `w_en_o = ex_reg_wen_i`; `rd_id_o = ex_rd_id_i`.
  - Data is `ex_pc_plus4_i` when sel is PC4_SEL, otherwise `ex_alu_result_i`.
  - `stall_o = 0`; state stays IDLE.
- **IDLE, load, misaligned** (LH/LHU with `addr[0]=1`, or LW with `addr[1:0]!=0`):
  - `load_misaligned_o = 1`; no request, no write, `stall_o = 0`; state stays IDLE.
- **IDLE, load, aligned**:
  - Latch addr[1:0], funct3, rd, reg_wen.
  - `mem_req_o = 1`, `stall_o = 1`, `w_en_o = 0`.
  - Next state: WAIT if `mem_ready_i` is high, else REQ.
- **REQ**: `mem_req_o = 1` with the latched address; `stall_o = 1`; go to WAIT on `mem_ready_i`.
- **WAIT**:
  - `stall_o = 1`.
  - On `mem_rvalid_i`: capture the extended data, go to WB.
  - `mem_rvalid_i` is sampled only in WAIT and ignored in every other state.
- **WB**:
  - `w_en_o` = latched reg_wen; `rd_id_o` = latched rd; `rd_write_data_o` = captured data.
  - `stall_o = 0`, so the load retires this cycle; state returns to IDLE.
  - `ex_*` inputs are ignored in WB.
- **Extension**: byte lane is `rdata[8*addr[1:0] +: 8]`, halfword lane is `rdata[16*addr[1] +: 16]`. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- **rd = 0**: forwarded unchanged; `regfile` discards the write.
- **`ex_valid_i` low in IDLE**: all outputs 0.

## Timing
- **Reset**: state IDLE; latches cleared; `mem_req_o`, `mem_addr_o`, `stall_o`, `w_en_o`, `rd_id_o`, `rd_write_data_o` and `load_misaligned_o` all 0 in the cycle after `rst` is sampled high.
- **Non-load latency**: zero cycles; the write lands at the same posedge.
- **Zero-wait load** (ready in the issue cycle, rvalid one cycle later): 3 cycles (IDLE, WAIT, WB); `stall_o` high for 2 cycles.
- **Each extra cycle** of ready or rvalid delay adds one stall cycle.
- **Handshake**: a request transfers on `mem_req_o & mem_ready_i`. Once asserted, `mem_req_o` and `mem_addr_o` hold stable until accepted. At most one request is outstanding.
- **Reset mid-load**: returns to IDLE and drops the outstanding read; a later `mem_rvalid_i` is ignored and produces no write.

## Test plan
- ADDI-type: `ex_valid=1`, `reg_wen=1`, `rd=5`, `sel=00`, `alu=0x1234` -> same cycle `w_en_o=1`, `rd_id_o=5`, `rd_write_data_o=0x1234`, `stall_o=0`.
- JAL: `sel=10`, `pc_plus4=0x80000008`, `rd=1` -> writes 0x80000008 to rd 1; `stall_o=0`.
- LB at 0x1003, `rdata=0x80FF_7F01`, zero-wait memory -> stall 2 cycles; `mem_addr_o=0x1000`; WB writes 0xFFFFFF80. Repeat as LBU -> 0x00000080.
- LH at 0x2002, ready delayed 2 cycles, rvalid delayed 3, `rdata=0x8001_0000` -> `mem_req_o` stable through REQ; WB writes 0xFFFF8001 after 7 total cycles.
- LW at 0x3001 -> `load_misaligned_o=1` for one cycle; `mem_req_o=0`, `w_en_o=0`, `stall_o=0`.
- Reset asserted in WAIT, then `mem_rvalid_i=1` -> state IDLE, no `w_en_o` pulse, `stall_o=0`.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: picks the value retired into rd and sequences loads over a
// valid/ready data-memory read port, stalling the core while a load is in flight.
module writeback_unit #(
  parameter logic [1:0] LOAD_SEL = 2'b01,
  parameter logic [1:0] PC4_SEL  = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic        ex_reg_wen_i,
  input  logic [4:0]  ex_rd_id_i,
  input  logic [1:0]  ex_wb_sel_i,
  input  logic [31:0] ex_alu_result_i,
  input  logic [31:0] ex_pc_plus4_i,
  input  logic [2:0]  ex_load_funct3_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        w_en_o,
  output logic [4:0]  rd_id_o,
  output logic [31:0] rd_write_data_o,
  output logic        load_misaligned_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        wen_q, wen_d;
  logic [31:0] data_q, data_d;

  // Unlisted funct3 encodings behave as LW, so they need full word alignment.
  function automatic logic is_misaligned(input logic [1:0] lo, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: is_misaligned = 1'b0;
      3'b001, 3'b101: is_misaligned = lo[0];
      default:        is_misaligned = |lo;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] lo,
                                         input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = w[16*lo[1] +: 16];
    case (f3)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b100:  extend = {24'b0, b};
      3'b101:  extend = {16'b0, h};
      default: extend = w;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d           = state_q;
    addr_d            = addr_q;
    funct3_d          = funct3_q;
    rd_d              = rd_q;
    wen_d             = wen_q;
    data_d            = data_q;
    mem_req_o         = 1'b0;
    mem_addr_o        = 32'b0;
    stall_o           = 1'b0;
    w_en_o            = 1'b0;
    rd_id_o           = 5'b0;
    rd_write_data_o   = 32'b0;
    load_misaligned_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          if (ex_wb_sel_i != LOAD_SEL) begin
            w_en_o          = ex_reg_wen_i;
            rd_id_o         = ex_rd_id_i;
            rd_write_data_o = (ex_wb_sel_i == PC4_SEL) ? ex_pc_plus4_i : ex_alu_result_i;
          end else if (is_misaligned(ex_alu_result_i[1:0], ex_load_funct3_i)) begin
            load_misaligned_o = 1'b1;
          end else begin
            addr_d     = ex_alu_result_i;
            funct3_d   = ex_load_funct3_i;
            rd_d       = ex_rd_id_i;
            wen_d      = ex_reg_wen_i;
            mem_req_o  = 1'b1;
            mem_addr_o = {ex_alu_result_i[31:2], 2'b00};
            stall_o    = 1'b1;
            state_d    = mem_ready_i ? WAIT : REQ;
          end
        end
      end
      REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_q[31:2], 2'b00};
        stall_o    = 1'b1;
        if (mem_ready_i) state_d = WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) begin
          data_d  = extend(mem_rdata_i, addr_q[1:0], funct3_q);
          state_d = WB;
        end
      end
      WB: begin
        w_en_o          = wen_q;
        rd_id_o         = rd_q;
        rd_write_data_o = data_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= 32'b0;
      funct3_q <= 3'b0;
      rd_q     <= 5'b0;
      wen_q    <= 1'b0;
      data_q   <= 32'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      wen_q    <= wen_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus queues expected regfile writes,
// a negedge monitor pops and compares them whenever w_en_o fires.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, ex_reg_wen_i;
  logic [4:0]  ex_rd_id_i;
  logic [1:0]  ex_wb_sel_i;
  logic [31:0] ex_alu_result_i, ex_pc_plus4_i;
  logic [2:0]  ex_load_funct3_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, w_en_o, load_misaligned_o;
  logic [4:0]  rd_id_o;
  logic [31:0] rd_write_data_o;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  writeback_unit dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_reg_wen_i(ex_reg_wen_i), .ex_rd_id_i(ex_rd_id_i),
    .ex_wb_sel_i(ex_wb_sel_i), .ex_alu_result_i(ex_alu_result_i),
    .ex_pc_plus4_i(ex_pc_plus4_i), .ex_load_funct3_i(ex_load_funct3_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .w_en_o(w_en_o), .rd_id_o(rd_id_o),
    .rd_write_data_o(rd_write_data_o), .load_misaligned_o(load_misaligned_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (w_en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'b0, w_en_o}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wb_rd", {27'b0, rd_id_o}, {27'b0, e.rd});
        check("wb_data", rd_write_data_o, e.data);
      end
    end
  end

  task automatic idle_inputs();
    ex_valid_i = 0; ex_reg_wen_i = 0; ex_rd_id_i = 0; ex_wb_sel_i = 0;
    ex_alu_result_i = 0; ex_pc_plus4_i = 0; ex_load_funct3_i = 0;
    mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  // Non-load instruction: the write must appear in the same cycle with no stall.
  task automatic run_alu(input logic wen, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] exp_data);
    ex_valid_i = 1; ex_reg_wen_i = wen; ex_rd_id_i = rd; ex_wb_sel_i = sel;
    ex_alu_result_i = alu; ex_pc_plus4_i = pc4;
    if (wen) exp_q.push_back('{rd: rd, data: exp_data});
    @(negedge clk);
    check("alu_stall", {31'b0, stall_o}, 32'd0);
    check("alu_req", {31'b0, mem_req_o}, 32'd0);
    check("alu_wen", {31'b0, w_en_o}, {31'b0, wen});
    @(posedge clk); #1;
    ex_valid_i = 0;
  endtask

  // Load with ready after rdy_dly cycles and rvalid after rv_dly WAIT cycles.
  // rvalid is pulsed with junk data while still in IDLE/REQ to show it is ignored there.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] rdata, input int rdy_dly, input int rv_dly,
                          input logic [31:0] exp_data);
    int stalls = 0;
    ex_valid_i = 1; ex_reg_wen_i = 1; ex_rd_id_i = rd; ex_wb_sel_i = 2'b01;
    ex_alu_result_i = addr; ex_load_funct3_i = f3;
    exp_q.push_back('{rd: rd, data: exp_data});
    for (int i = 0; i <= rdy_dly; i++) begin
      mem_ready_i  = (i == rdy_dly);
      mem_rvalid_i = (i > 0);
      mem_rdata_i  = 32'h5A5A_5A5A;
      @(negedge clk);
      check("ld_req", {31'b0, mem_req_o}, 32'd1);
      check("ld_addr", mem_addr_o, {addr[31:2], 2'b00});
      check("ld_wen_busy", {31'b0, w_en_o}, 32'd0);
      if (stall_o) stalls++;
      @(posedge clk); #1;
    end
    mem_ready_i = 0;
    for (int i = 0; i <= rv_dly; i++) begin
      mem_rvalid_i = (i == rv_dly);
      mem_rdata_i  = (i == rv_dly) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      check("ld_wait_req", {31'b0, mem_req_o}, 32'd0);
      if (stall_o) stalls++;
      @(posedge clk); #1;
    end
    mem_rvalid_i = 0;
    @(negedge clk);
    check("ld_wb_stall", {31'b0, stall_o}, 32'd0);
    check("ld_stall_cycles", stalls, rdy_dly + rv_dly + 2);
    @(posedge clk); #1;
    ex_valid_i = 0;
  endtask

  task automatic run_misaligned(input logic [31:0] addr, input logic [2:0] f3);
    ex_valid_i = 1; ex_reg_wen_i = 1; ex_rd_id_i = 5'd9; ex_wb_sel_i = 2'b01;
    ex_alu_result_i = addr; ex_load_funct3_i = f3;
    @(negedge clk);
    check("mis_flag", {31'b0, load_misaligned_o}, 32'd1);
    check("mis_req", {31'b0, mem_req_o}, 32'd0);
    check("mis_wen", {31'b0, w_en_o}, 32'd0);
    check("mis_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1;
    ex_valid_i = 0;
    @(negedge clk);
    check("mis_flag_clear", {31'b0, load_misaligned_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("rst_outputs",
          {mem_req_o, stall_o, w_en_o, load_misaligned_o, rd_id_o, 23'b0}, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_data", rd_write_data_o, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    run_alu(1, 5'd5, 2'b00, 32'h0000_1234, 32'h0, 32'h0000_1234);            // ADDI
    run_alu(1, 5'd1, 2'b10, 32'h0000_0040, 32'h8000_0008, 32'h8000_0008);    // JAL
    run_alu(1, 5'd7, 2'b11, 32'hDEAD_BEEF, 32'h1111_1111, 32'hDEAD_BEEF);    // sel 11 -> ALU
    run_alu(0, 5'd3, 2'b00, 32'hCAFE_0000, 32'h0, 32'h0);                    // no rd write
    run_alu(1, 5'd0, 2'b00, 32'h0000_00AA, 32'h0, 32'h0000_00AA);            // rd 0 forwarded

    run_load(32'h0000_1003, 3'b000, 5'd10, 32'h80FF_7F01, 0, 0, 32'hFFFF_FF80); // LB
    run_load(32'h0000_1003, 3'b100, 5'd11, 32'h80FF_7F01, 0, 0, 32'h0000_0080); // LBU
    run_load(32'h0000_1001, 3'b000, 5'd12, 32'h80FF_7F01, 0, 1, 32'h0000_007F); // LB lane 1
    // LH: IDLE, REQ, REQ, WAIT x3, WB = 7 cycles
    run_load(32'h0000_2002, 3'b001, 5'd13, 32'h8001_0000, 2, 2, 32'hFFFF_8001);
    run_load(32'h0000_2000, 3'b101, 5'd14, 32'h1234_ABCD, 1, 0, 32'h0000_ABCD); // LHU
    run_load(32'h0000_3000, 3'b010, 5'd15, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D); // LW
    run_load(32'h0000_3004, 3'b011, 5'd16, 32'h8765_4321, 0, 0, 32'h8765_4321); // funct3 011 as LW

    run_misaligned(32'h0000_3001, 3'b010);   // LW
    run_misaligned(32'h0000_2003, 3'b101);   // LHU
    run_misaligned(32'h0000_3002, 3'b110);   // unlisted funct3 as LW

    // Reset while in WAIT: the late rvalid must not produce a write.
    ex_valid_i = 1; ex_reg_wen_i = 1; ex_rd_id_i = 5'd20; ex_wb_sel_i = 2'b01;
    ex_alu_result_i = 32'h0000_4000; ex_load_funct3_i = 3'b010; mem_ready_i = 1;
    @(posedge clk); #1;
    mem_ready_i = 0; ex_valid_i = 0; rst = 1;
    @(negedge clk);
    check("rst_wait_stall", {31'b0, stall_o}, 32'd1);
    @(posedge clk); #1;
    rst = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1357_9BDF;
    @(negedge clk);
    check("rst_mid_stall", {31'b0, stall_o}, 32'd0);
    check("rst_mid_wen", {31'b0, w_en_o}, 32'd0);
    check("rst_mid_req", {31'b0, mem_req_o}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid_i = 0;
    @(negedge clk);
    check("rst_after_wen", {31'b0, w_en_o}, 32'd0);
    @(posedge clk); #1;

    run_alu(1, 5'd31, 2'b00, 32'h0BAD_F00D, 32'h0, 32'h0BAD_F00D);           // recovers cleanly

    repeat (2) @(posedge clk);
    check("pending_writes", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
